// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
//   Handshake and status bundle of one inter-stage pipeline register.
//   slave  : the stage itself (consumes upstream, drives downstream/status)
//   master : the surrounding pipeline / bench (drives upstream, reads rest)
//   Signals:
//     FlushIn   discard held entries and the current input
//     InValid   upstream slot valid        InReady   stage can accept
//     InCtrl    upstream control bundle    InData    upstream data bundle
//     OutValid  downstream slot valid      OutReady  downstream accepts
//     OutCtrl   control bundle, zero when OutValid=0
//     OutData   data bundle of the head entry
//     Occupancy entries held (0..2)        StallCnt  saturating stall count
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
);
  logic              FlushIn;
  logic              InValid;
  logic              InReady;
  logic [CTRL_W-1:0] InCtrl;
  logic [DATA_W-1:0] InData;
  logic              OutValid;
  logic              OutReady;
  logic [CTRL_W-1:0] OutCtrl;
  logic [DATA_W-1:0] OutData;
  logic [1:0]        Occupancy;
  logic [CNT_W-1:0]  StallCnt;

  modport slave (
    input  FlushIn, InValid, InCtrl, InData, OutReady,
    output InReady, OutValid, OutCtrl, OutData, Occupancy, StallCnt
  );

  modport master (
    output FlushIn, InValid, InCtrl, InData, OutReady,
    input  InReady, OutValid, OutCtrl, OutData, Occupancy, StallCnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic inter-stage register for the 5-stage MIPS32 pipeline. Holds a
//   control bundle and a data bundle behind a valid/ready handshake, with a
//   one-deep skid entry so that InReady can be derived from state only
//   (no combinational path from OutReady). Invalid or flushed slots present
//   an all-zero control bundle (bubble). Counts stall cycles for debug.
//   Ports:
//     CLK  rising-edge clock
//     RST  synchronous active-high reset
//     bus  pipe_stage_skid_if.slave (handshake, bundles, status)
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  pipe_stage_skid_if.slave     bus
);

  // Occupancy-coded states: main entry only = ONE, skid also valid = FULL.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_state;

  // The skid entry is only ever filled while main is valid, so the two
  // valid bits fully encode the state.
  assign w_state    = r_skid_valid ? ST_FULL : (r_main_valid ? ST_ONE : ST_EMPTY);
  assign w_in_ready = ~r_skid_valid & ~RST;
  assign w_push     = bus.InValid & w_in_ready;
  assign w_pop      = r_main_valid & bus.OutReady;

  always_ff @(posedge CLK) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (RST) begin
      // NOTE: the datapath registers are reset too, because OutData must
      // read zero after reset, not just be masked by OutValid.
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      // Stall accounting looks at the pre-update state; flush does not
      // touch it.
      if (r_main_valid && !bus.OutReady && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      if (bus.FlushIn) begin
        // Main data is left alone so OutData stays stable while invalid.
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
        r_skid_ctrl  <= '0;
        r_skid_data  <= '0;
      end else begin
        case (w_state)
          ST_EMPTY: begin
            if (w_push) begin
              r_main_valid <= 1'b1;
              r_main_ctrl  <= bus.InCtrl;
              r_main_data  <= bus.InData;
            end
          end
          ST_ONE: begin
            if (w_push && w_pop) begin
              r_main_ctrl  <= bus.InCtrl;
              r_main_data  <= bus.InData;
            end else if (w_push) begin
              r_skid_valid <= 1'b1;
              r_skid_ctrl  <= bus.InCtrl;
              r_skid_data  <= bus.InData;
            end else if (w_pop) begin
              r_main_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            // InReady is low here, so only a pop can happen.
            if (w_pop) begin
              r_main_ctrl  <= r_skid_ctrl;
              r_main_data  <= r_skid_data;
              r_skid_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.InReady   = w_in_ready;
  assign bus.OutValid  = r_main_valid;
  assign bus.OutCtrl   = r_main_valid ? r_main_ctrl : '0;
  assign bus.OutData   = r_main_data;
  assign bus.Occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign bus.StallCnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Two instances share one stimulus stream: the default-width stage and a
//   CNT_W=4 stage for counter saturation. A queue-based model predicts
//   every output after every clock edge; directed sections pin the model
//   with literal expectations, then a randomized phase runs long traffic.
module tb_pipe_stage_skid;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 69;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk;
  logic rst;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) bus ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4))  bus4 ();

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .bus(bus4)
  );

  assign bus4.FlushIn  = bus.FlushIn;
  assign bus4.InValid  = bus.InValid;
  assign bus4.InCtrl   = bus.InCtrl;
  assign bus4.InData   = bus.InData;
  assign bus4.OutReady = bus.OutReady;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state
  entry_t            q[$];
  logic [DATA_W-1:0] m_shown = '0;
  int                m_cnt16 = 0;
  int                m_cnt4  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic fl, input logic vld,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic rdy);
    rst          = r;
    bus.FlushIn  = fl;
    bus.InValid  = vld;
    bus.InCtrl   = c;
    bus.InData   = d;
    bus.OutReady = rdy;
  endtask

  // Advance the model by one edge from the current inputs, clock the DUTs,
  // then compare every output of both instances against the model.
  task automatic step();
    bit     in_rdy, push, pop, vld;
    entry_t e;
    in_rdy = !rst && (q.size() < 2);
    push   = bus.InValid && in_rdy;
    pop    = (q.size() > 0) && bus.OutReady;
    if (rst) begin
      q.delete();
      m_shown = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      if ((q.size() > 0) && !bus.OutReady) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4  < 15)    m_cnt4++;
      end
      if (bus.FlushIn) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          e.ctrl = bus.InCtrl;
          e.data = bus.InData;
          q.push_back(e);
        end
        if (q.size() > 0) m_shown = q[0].data;
      end
    end
    @(posedge clk);
    #1;
    vld = q.size() > 0;
    check("InReady",    bus.InReady,   !rst && (q.size() < 2));
    check("OutValid",   bus.OutValid,  vld);
    check("OutCtrl",    bus.OutCtrl,   vld ? q[0].ctrl : '0);
    check("OutData",    bus.OutData,   m_shown);
    check("Occupancy",  bus.Occupancy, q.size());
    check("StallCnt",   bus.StallCnt,  m_cnt16);
    check("OutValid4",  bus4.OutValid, vld);
    check("OutData4",   bus4.OutData,  m_shown);
    check("Occupancy4", bus4.Occupancy, q.size());
    check("StallCnt4",  bus4.StallCnt, m_cnt4);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] rd;

    // Reset with an active upstream: bubble out, nothing accepted.
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 69'h1F, 1'b1);
    step();
    step();
    check("rst_inready", bus.InReady, 1'b0);
    check("rst_outvalid", bus.OutValid, 1'b0);
    check("rst_outctrl", bus.OutCtrl, 8'h00);
    check("rst_occ", bus.Occupancy, 2'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    check("post_rst_inready", bus.InReady, 1'b1);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h80 | 8'(i), 69'(i), 1'b1);
      step();
      check("stream_data", bus.OutData, 69'(i));
      check("stream_ctrl", bus.OutCtrl, 8'h80 | 8'(i));
      check("stream_occ", bus.Occupancy, 2'd1);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step();
    check("stream_stall", bus.StallCnt, 16'd0);
    check("stream_drained", bus.OutValid, 1'b0);

    // Backpressure into the skid entry.
    drive(1'b0, 1'b0, 1'b1, 8'h0A, 69'hA, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 8'h0B, 69'hB, 1'b0);
    step();
    check("bp_occ", bus.Occupancy, 2'd2);
    check("bp_inready", bus.InReady, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("bp_stall", bus.StallCnt, 16'd6);
    check("bp_head_a", bus.OutData, 69'hA);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step();
    check("bp_head_b", bus.OutData, 69'hB);
    check("bp_inready_back", bus.InReady, 1'b1);
    step();
    check("bp_empty", bus.OutValid, 1'b0);

    // Flush beats a simultaneous push and pop.
    drive(1'b0, 1'b0, 1'b1, 8'h11, 69'h11, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 8'h12, 69'h12, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b1, 8'h0C, 69'hC, 1'b1);
    step();
    check("fl_valid", bus.OutValid, 1'b0);
    check("fl_ctrl", bus.OutCtrl, 8'h00);
    check("fl_occ", bus.Occupancy, 2'd0);
    check("fl_data_kept", bus.OutData, 69'h11);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step();
    check("fl_no_c", bus.OutValid, 1'b0);

    // Counter saturation on the narrow instance.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h21, 69'h21, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt4", bus4.StallCnt, 4'd15);
    check("sat_cnt16", bus.StallCnt, 16'd20);

    // Reset mid-operation wins over flush and push.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h31, 69'h31, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 8'h32, 69'h32, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    step();
    check("mid_stall3", bus.StallCnt, 16'd3);
    check("mid_full", bus.Occupancy, 2'd2);
    drive(1'b1, 1'b1, 1'b1, 8'h77, 69'h77, 1'b1);
    step();
    check("mid_valid", bus.OutValid, 1'b0);
    check("mid_data", bus.OutData, 69'h0);
    check("mid_occ", bus.Occupancy, 2'd0);
    check("mid_stall", bus.StallCnt, 16'd0);
    drive(1'b0, 1'b0, 1'b1, 8'h55, 69'h55, 1'b1);
    step();
    check("mid_first", bus.OutData, 69'h55);
    check("mid_alone", bus.Occupancy, 2'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step();
    check("mid_done", bus.Occupancy, 2'd0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      rd = {$urandom(), $urandom(), 5'($urandom())};
      drive($urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 70,
            8'($urandom()), rd,
            $urandom_range(0, 99) < 60);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS32 core, generalising the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush.
- Converts a control field into a bubble (zeroed) whenever the slot is invalid or flushed.
- Counts stall cycles for performance debug.

Parameters:
CTRL_W, 8, control-bit bundle width (RegWrite, MemtoReg, MemWrite, Load, Fwd, Stop, ...); zeroed on bubble.
DATA_W, 69, data bundle width (e.g. ALUOut 32 + WriteData 32 + WriteReg 5); never zeroed except at reset.
CNT_W, 16, stall counter width.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
FlushIn  input  1  discard all held entries and the current input
InValid  input  1  upstream slot valid
InReady  output  1  stage can accept this cycle
InCtrl  input  CTRL_W  upstream control bundle
InData  input  DATA_W  upstream data bundle
OutValid  output  1  downstream slot valid
OutReady  input  1  downstream accepts this cycle
OutCtrl  output  CTRL_W  control bundle; all zero when OutValid=0
OutData  output  DATA_W  data bundle of head entry
Occupancy  output  2  entries held (0, 1 or 2)
StallCnt  output  CNT_W  saturating count of cycles with OutValid=1 and OutReady=0

Behaviour:
- Clock and reset: one clock CLK; RST is synchronous, active-high, and sampled only at the CLK rising edge.
- Reset: OutValid=0, OutCtrl=0, OutData=0, Occupancy=0, StallCnt=0, skid entry cleared. InReady=0 while RST=1.
- Handshake: push = InValid & InReady; pop = OutValid & OutReady. Entries leave in FIFO order with no loss and no duplication.
- InReady is a registered value: InReady = !skid_valid & !RST. It has no combinational path from OutReady.
- Latency: an accepted entry appears on OutValid/OutCtrl/OutData in the next cycle when the stage was empty, or was ONE and popping.
- State EMPTY (Occupancy 0):
  - push -> ONE; main <= input.
- State ONE (Occupancy 1):
  - push & pop -> ONE; main <= input.
  - push & !pop -> FULL; skid <= input.
  - pop & !push -> EMPTY.
  - neither -> hold.
- State FULL (Occupancy 2, InReady=0, push impossible):
  - pop -> ONE; main <= skid.
  - otherwise hold.
- Flush: FlushIn=1 at an edge -> EMPTY, Occupancy=0, OutCtrl=0, skid cleared.
  - Flush beats push and pop in the same cycle; a simultaneous input is dropped.
  - OutData keeps its old value. StallCnt is unaffected.
- Reset priority: RST beats FlushIn. RST mid-operation drops all entries and clears StallCnt.
- Bubble rule: OutCtrl = main_ctrl when OutValid=1, else 0. OutData is don't-care when invalid but must be stable (no toggling).
- Stall counter: increments on every edge where OutValid & !OutReady holds before the update. It saturates at 2^CNT_W-1 and does not wrap. It is cleared only by RST.
- Hold: with no push, no pop and no flush, all outputs are unchanged.

Test Plan:
- Reset/bubble: RST=1 for 2 cycles, InValid=1, InCtrl=8'hFF -> InReady=0, OutValid=0, OutCtrl=0, Occupancy=0. After RST drops, InReady=1.
- Streaming: OutReady=1, push 4 entries with InData=1,2,3,4 on consecutive cycles -> OutData=1,2,3,4 on cycles 1-4, Occupancy stays 1, StallCnt=0.
- Backpressure/skid: push A=0xA, B=0xB with OutReady=0.
  - Occupancy=2, InReady=0 from the cycle after B.
  - Holding OutReady=0 for 5 cycles -> StallCnt=6 (cycles with OutValid=1, OutReady=0).
  - Raising OutReady -> A, then B, then InReady=1.
- Flush priority: FULL state, assert FlushIn with InValid=1, InData=0xC, OutReady=1 -> next cycle OutValid=0, OutCtrl=0, Occupancy=0; 0xC never appears on output.
- Saturation: CNT_W=4, OutReady=0 held 20 cycles with one entry -> StallCnt stops at 15.
- Reset mid-operation: FULL plus StallCnt=3, RST=1 together with FlushIn=1 and a push -> all outputs at reset values; first post-reset push is delivered alone.
